bus_encoder_arbiter: RTL



---
 rtl/bus_encoder_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_encoder_arbiter.sv
// Round-robin bus-source arbiter: one-hot Xout requests in, registered Code/grant out.
// Optional macro BUS_HOLD_TIMEOUT_EN bounds HOLD to HOLD_MAX consecutive cycles.
module bus_encoder_arbiter #(
    parameter int NUM_SRC   = 25,
    parameter int CODE_W    = 5,
    parameter int IDLE_CODE = 0,
    parameter int HOLD_MAX  = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] out_req,
    input  logic               hold,
    output logic [CODE_W-1:0]  Code,
    output logic [NUM_SRC-1:0] grant,
    output logic               bus_valid,
    output logic               conflict,
    output logic [7:0]         conflict_count,
    output logic               hold_timeout
);

    if ((2 ** CODE_W) < NUM_SRC || HOLD_MAX < 1) begin : g_bad_params
        $error("bus_encoder_arbiter: illegal NUM_SRC/CODE_W/HOLD_MAX");
    end

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   ptr, ptr_nxt;
    logic [CODE_W-1:0]   code_nxt;
    logic [NUM_SRC-1:0]  grant_nxt;
    logic                valid_nxt;
    logic [CODE_W-1:0]   win;
    logic                win_vld;
    logic [CODE_W:0]     idx;
    logic                owner_holds;
    logic                force_rel;
    logic                keep;
    logic                eff_hold;

    // Rotating priority: first requester after the last winner, wrapping to 0.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            idx = {1'b0, ptr} + (CODE_W+1)'(off);
            if (idx >= (CODE_W+1)'(NUM_SRC))
                idx = idx - (CODE_W+1)'(NUM_SRC);
            if (!win_vld && out_req[idx[CODE_W-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[CODE_W-1:0];
            end
        end
    end

    assign owner_holds = (state == HOLD) && hold && out_req[ptr];

`ifdef BUS_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    assign force_rel = owner_holds && (hold_cnt == CNT_W'(HOLD_MAX));

    // Counts held cycles of the current owner; 1 on the edge that enters HOLD.
    always_ff @(posedge clock) begin
        if (clear)
            hold_cnt <= '0;
        else if (keep)
            hold_cnt <= hold_cnt + 1'b1;
        else if (win_vld && eff_hold)
            hold_cnt <= CNT_W'(1);
        else
            hold_cnt <= '0;
    end

    always_ff @(posedge clock) begin
        if (clear) timeout_q <= 1'b0;
        else       timeout_q <= force_rel;
    end
    assign hold_timeout = timeout_q;
`else
    assign force_rel    = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    assign keep     = owner_holds && !force_rel;
    assign eff_hold = hold && !force_rel;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        code_nxt  = Code;
        grant_nxt = grant;
        valid_nxt = bus_valid;
        if (!keep) begin
            if (win_vld) begin
                state_nxt = eff_hold ? HOLD : GRANT;
                ptr_nxt   = win;
                code_nxt  = win;
                grant_nxt = NUM_SRC'(1) << win;
                valid_nxt = 1'b1;
            end else begin
                state_nxt = IDLE;
                code_nxt  = CODE_W'(IDLE_CODE);
                grant_nxt = '0;
                valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            ptr       <= CODE_W'(NUM_SRC - 1);
            Code      <= CODE_W'(IDLE_CODE);
            grant     <= '0;
            bus_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            Code      <= code_nxt;
            grant     <= grant_nxt;
            bus_valid <= valid_nxt;
        end
    end

    // Conflict tracking runs every cycle, independent of arbitration state.
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else begin
            conflict <= ($countones(out_req) > 1);
            if (($countones(out_req) > 1) && (conflict_count != 8'hFF))
                conflict_count <= conflict_count + 8'd1;
        end
    end

endmodule
